// File: rtl/modport_mem.sv
// Small synchronous register file: one write and one read port sharing an address bus.
// The read path is registered and sees the pre-write contents when both ports hit one word.
module modport_mem #(
  parameter int                    ADDR_WIDTH = 2,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  // One register per word; an X enable fails the if-test and acts as 0.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    always_ff @(posedge clk) begin
      if (reset)
        mem[i] <= RESET_VAL;
      else if (wr_en && (addr == ADDR_WIDTH'(i)))
        mem[i] <= wdata;
    end
  end

  // mem[addr] is sampled before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (reset)
      rdata <= '0;
    else if (rd_en)
      rdata <= mem[addr];
  end
endmodule

// File: tb/tb_modport_mem.sv
// Bench for modport_mem: directed vector table, mid-traffic reset sequence and
// randomized traffic checked against an array-based reference model.
module tb_modport_mem;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wdata;
  logic [7:0] rdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [4];
  logic [7:0] ref_rdata;

  typedef struct {
    logic       r;
    logic [1:0] a;
    logic       we;
    logic       re;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  modport_mem dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en),
    .rd_en(rd_en), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: rdata=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle, advance the reference model, compare rdata against it.
  task automatic step(input logic r, input logic [1:0] a, input logic we,
                      input logic re, input logic [7:0] wd, input string name);
    reset = r; addr = a; wr_en = we; rd_en = re; wdata = wd;
    @(posedge clk);
    #1;
    if (r) begin
      foreach (ref_mem[i]) ref_mem[i] = 8'hFF;
      ref_rdata = 8'h00;
    end else begin
      if (re) ref_rdata = ref_mem[a];
      if (we) ref_mem[a] = wd;
    end
    chk(name, rdata, ref_rdata);
  endtask

  function automatic vec_t mk(logic r, logic [1:0] a, logic we, logic re,
                              logic [7:0] wd, logic [7:0] exp);
    vec_t v;
    v.r = r; v.a = a; v.we = we; v.re = re; v.wd = wd; v.exp = exp;
    return v;
  endfunction

  initial begin
    reset = 1'b1; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    foreach (ref_mem[i]) ref_mem[i] = 8'hFF;
    ref_rdata = 8'h00;

    // reset, then read every address
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 2'(i), 0, 1, 8'h00, 8'hFF));
    // write/read back, others untouched
    tbl.push_back(mk(0, 2, 1, 0, 8'hA5, 8'hFF));
    tbl.push_back(mk(0, 2, 0, 1, 8'h00, 8'hA5));
    tbl.push_back(mk(0, 0, 0, 1, 8'h00, 8'hFF));
    tbl.push_back(mk(0, 1, 0, 1, 8'h00, 8'hFF));
    tbl.push_back(mk(0, 3, 0, 1, 8'h00, 8'hFF));
    // back-to-back writes, read in reverse
    tbl.push_back(mk(0, 0, 1, 0, 8'h11, 8'hFF));
    tbl.push_back(mk(0, 1, 1, 0, 8'h22, 8'hFF));
    tbl.push_back(mk(0, 2, 1, 0, 8'h33, 8'hFF));
    tbl.push_back(mk(0, 3, 1, 0, 8'h44, 8'hFF));
    tbl.push_back(mk(0, 3, 0, 1, 8'h00, 8'h44));
    tbl.push_back(mk(0, 2, 0, 1, 8'h00, 8'h33));
    tbl.push_back(mk(0, 1, 0, 1, 8'h00, 8'h22));
    tbl.push_back(mk(0, 0, 0, 1, 8'h00, 8'h11));
    // simultaneous read/write returns old data
    tbl.push_back(mk(0, 1, 1, 1, 8'h5A, 8'h22));
    tbl.push_back(mk(0, 1, 0, 1, 8'h00, 8'h5A));
    // hold while rd_en is low
    tbl.push_back(mk(0, 2, 0, 1, 8'h00, 8'h33));
    tbl.push_back(mk(0, 0, 1, 0, 8'h66, 8'h33));
    tbl.push_back(mk(0, 3, 1, 0, 8'h99, 8'h33));
    tbl.push_back(mk(0, 1, 0, 0, 8'hC3, 8'h33));
    tbl.push_back(mk(0, 0, 0, 1, 8'h00, 8'h66));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].a, tbl[i].we, tbl[i].re, tbl[i].wd, $sformatf("model_vec%0d", i));
      chk($sformatf("table_vec%0d", i), rdata, tbl[i].exp);
    end

    // reset lands on a write of 77 to addr 0: write discarded
    step(0, 3, 0, 1, 8'h00, "pre_reset_read");
    chk("pre_reset_read_const", rdata, 8'h99);
    step(1, 0, 1, 1, 8'h77, "mid_reset");
    chk("mid_reset_rdata", rdata, 8'h00);
    step(0, 0, 0, 0, 8'h00, "post_reset_idle");
    chk("post_reset_hold", rdata, 8'h00);
    step(0, 0, 0, 1, 8'h00, "post_reset_rd0");
    chk("post_reset_mem0", rdata, 8'hFF);
    step(0, 3, 0, 1, 8'h00, "post_reset_rd3");
    chk("post_reset_mem3", rdata, 8'hFF);

    // randomized traffic, with occasional resets
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
